// File: rtl/cpu_ctrl_pkg.sv
// Shared run-control types: controller state and halt cause codes, used by the
// run controller, the CPU top and benches.
package cpu_ctrl_pkg;

    localparam int CNT_W = 32;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_HALT = 2'd1,
        ST_STEP = 2'd2
    } run_state_t;

    typedef enum logic [2:0] {
        CAUSE_NONE    = 3'd0,
        CAUSE_HOST    = 3'd1,
        CAUSE_EBREAK  = 3'd2,
        CAUSE_STEP    = 3'd3,
        CAUSE_TIMEOUT = 3'd4
    } halt_cause_t;

    // Reason for leaving a single step: an EBREAK or watchdog outranks a clean step.
    function automatic halt_cause_t step_exit_cause(input logic ebreak, input logic wd);
        if (ebreak)
            return CAUSE_EBREAK;
        else if (wd)
            return CAUSE_TIMEOUT;
        else
            return CAUSE_STEP;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Clearable up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            q_reg <= '0;
        else if (clr)
            q_reg <= '0;
        else if (inc && (q_reg != {WIDTH{1'b1}}))
            q_reg <= q_reg + 1'b1;
    end

    assign q = q_reg;

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run/halt/step controller: gates CPU commits, tracks why the core halted and
// counts committed cycles with an optional watchdog limit.
module cpu_run_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter bit               AUTO_RUN   = 1'b1,
    parameter logic [CNT_W-1:0] MAX_CYCLES = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run_req,
    input  logic             halt_req,
    input  logic             step_req,
    input  logic             ebreak_det,
    input  logic             cnt_clr,
    output logic             cpu_en,
    output logic             halted,
    output logic             step_done,
    output logic [2:0]       halt_cause,
    output logic [CNT_W-1:0] cycle_count
);

    localparam run_state_t RESET_STATE = AUTO_RUN ? ST_RUN : ST_HALT;

    run_state_t  state_reg;
    halt_cause_t cause_reg;
    logic        halted_reg;
    logic        step_done_reg;
    logic        wd_hit;
    logic        active;

    assign wd_hit = (MAX_CYCLES != '0) && (cycle_count == MAX_CYCLES);
    assign active = (state_reg == ST_RUN) || (state_reg == ST_STEP);

    // An EBREAK never commits, so the PC stays parked on it for the host.
    assign cpu_en = active && !ebreak_det && !wd_hit;

    sat_counter #(
        .WIDTH(CNT_W)
    ) u_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (cpu_en),
        .clr   (cnt_clr),
        .q     (cycle_count)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= RESET_STATE;
            halted_reg    <= !AUTO_RUN;
            cause_reg     <= CAUSE_NONE;
            step_done_reg <= 1'b0;
        end else begin
            step_done_reg <= 1'b0;
            case (state_reg)
                ST_RUN: begin
                    if (ebreak_det) begin
                        state_reg  <= ST_HALT;
                        halted_reg <= 1'b1;
                        cause_reg  <= CAUSE_EBREAK;
                    end else if (wd_hit) begin
                        state_reg  <= ST_HALT;
                        halted_reg <= 1'b1;
                        cause_reg  <= CAUSE_TIMEOUT;
                    end else if (halt_req) begin
                        // The instruction in this cycle still commits.
                        state_reg  <= ST_HALT;
                        halted_reg <= 1'b1;
                        cause_reg  <= CAUSE_HOST;
                    end
                end
                ST_HALT: begin
                    if (run_req) begin
                        state_reg  <= ST_RUN;
                        halted_reg <= 1'b0;
                    end else if (step_req) begin
                        state_reg  <= ST_STEP;
                        halted_reg <= 1'b0;
                    end
                end
                ST_STEP: begin
                    state_reg     <= ST_HALT;
                    halted_reg    <= 1'b1;
                    cause_reg     <= step_exit_cause(ebreak_det, wd_hit);
                    step_done_reg <= !ebreak_det && !wd_hit;
                end
                default: begin
                    state_reg  <= ST_HALT;
                    halted_reg <= 1'b1;
                end
            endcase
        end
    end

    assign halted     = halted_reg;
    assign step_done  = step_done_reg;
    assign halt_cause = cause_reg;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Bench for cpu_run_ctrl: directed program scenarios, a vector table, random
// stimulus against a rule-level model, and a narrow saturating-counter check.
module tb_cpu_run_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, run_req, halt_req, step_req, ebreak_det, cnt_clr;
    logic en0, halted0, sd0, en1, halted1, sd1;
    logic [2:0]  cause0, cause1;
    logic [31:0] cnt0, cnt1;
    logic        sat_inc, sat_clr;
    logic [3:0]  sat_q;

    cpu_run_ctrl #(.AUTO_RUN(1'b1), .MAX_CYCLES(32'd0)) dut0 (
        .clk(clk), .reset(reset), .run_req(run_req), .halt_req(halt_req),
        .step_req(step_req), .ebreak_det(ebreak_det), .cnt_clr(cnt_clr),
        .cpu_en(en0), .halted(halted0), .step_done(sd0),
        .halt_cause(cause0), .cycle_count(cnt0));

    cpu_run_ctrl #(.AUTO_RUN(1'b0), .MAX_CYCLES(32'd4)) dut1 (
        .clk(clk), .reset(reset), .run_req(run_req), .halt_req(halt_req),
        .step_req(step_req), .ebreak_det(ebreak_det), .cnt_clr(cnt_clr),
        .cpu_en(en1), .halted(halted1), .step_done(sd1),
        .halt_cause(cause1), .cycle_count(cnt1));

    sat_counter #(.WIDTH(4)) u_sat (
        .clk(clk), .reset(reset), .inc(sat_inc), .clr(sat_clr), .q(sat_q));

    int passed = 0;
    int total  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp)
            passed++;
        else
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Rule-level model: one entry per DUT instance.
    int     m_auto[2] = '{1, 0};
    longint m_max[2]  = '{0, 4};
    bit     m_halted[2], m_stepping[2], m_sd[2];
    int     m_cause[2];
    longint m_cnt[2];

    function automatic bit m_wd(int k);
        return (m_max[k] != 0) && (m_cnt[k] == m_max[k]);
    endfunction

    function automatic bit m_en(int k);
        return !m_halted[k] && !ebreak_det && !m_wd(k);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_halted[k]   = (m_auto[k] == 0);
            m_stepping[k] = 1'b0;
            m_sd[k]       = 1'b0;
            m_cause[k]    = 0;
            m_cnt[k]      = 0;
        end
    endtask

    task automatic model_edge();
        for (int k = 0; k < 2; k++) begin
            bit     wd = m_wd(k);
            bit     en = m_en(k);
            longint nc = cnt_clr ? 0 : ((en && m_cnt[k] != 64'hFFFF_FFFF) ? m_cnt[k] + 1 : m_cnt[k]);
            m_sd[k] = 1'b0;
            if (m_stepping[k]) begin
                m_stepping[k] = 1'b0;
                m_halted[k]   = 1'b1;
                if (ebreak_det)   m_cause[k] = 2;
                else if (wd)      m_cause[k] = 4;
                else begin        m_cause[k] = 3; m_sd[k] = 1'b1; end
            end else if (m_halted[k]) begin
                if (run_req)       m_halted[k] = 1'b0;
                else if (step_req) begin m_halted[k] = 1'b0; m_stepping[k] = 1'b1; end
            end else begin
                if (ebreak_det)    begin m_halted[k] = 1'b1; m_cause[k] = 2; end
                else if (wd)       begin m_halted[k] = 1'b1; m_cause[k] = 4; end
                else if (halt_req) begin m_halted[k] = 1'b1; m_cause[k] = 1; end
            end
            m_cnt[k] = nc;
        end
    endtask

    task automatic check_regs();
        chk("halted0", halted0, m_halted[0]);
        chk("step_done0", sd0, m_sd[0]);
        chk("cause0", cause0, m_cause[0]);
        chk("count0", cnt0, m_cnt[0][31:0]);
        chk("halted1", halted1, m_halted[1]);
        chk("step_done1", sd1, m_sd[1]);
        chk("cause1", cause1, m_cause[1]);
        chk("count1", cnt1, m_cnt[1][31:0]);
    endtask

    // Emulated program counter for dut0: advances 4 per commit.
    bit          use_prog = 1'b0;
    logic [31:0] pc = 0, eb_pc = 0;
    int          commits0 = 0, commits1 = 0, sd_pulses0 = 0;
    logic        last_en0;

    task automatic tick();
        logic e0, e1;
        #1;
        e0 = en0;
        e1 = en1;
        chk("cpu_en0", e0, m_en(0));
        chk("cpu_en1", e1, m_en(1));
        last_en0 = e0;
        @(posedge clk);
        model_edge();
        if (e0) begin pc += 4; commits0++; end
        if (e1) commits1++;
        #1;
        check_regs();
        sd_pulses0 += sd0;
        @(negedge clk);
        if (use_prog) ebreak_det = (pc == eb_pc);
    endtask

    // Entered at a falling edge; asserts reset asynchronously and checks it holds.
    task automatic do_reset();
        reset = 1'b0;
        #1;
        model_reset();
        pc = 0;
        check_regs();
        repeat (2) begin
            @(posedge clk);
            #1;
            check_regs();
        end
        @(negedge clk);
        reset = 1'b1;
        run_req = 0; halt_req = 0; step_req = 0; cnt_clr = 0;
        ebreak_det = use_prog ? (pc == eb_pc) : 1'b0;
    endtask

    typedef struct {
        logic [4:0]  in_bits;    // {run, halt, step, ebreak, clr}
        logic [2:0]  out_bits;   // {cpu_en, halted, step_done}
        logic [2:0]  cause;
        logic [31:0] count;
    } vec_t;

    typedef struct {
        logic       inc;
        logic       clr;
        logic [3:0] q;
    } sat_vec_t;

    vec_t     vt[15];
    sat_vec_t st[6];
    int       base_cnt, c_before;

    initial begin
        reset = 1'b0;
        run_req = 0; halt_req = 0; step_req = 0; ebreak_det = 0; cnt_clr = 0;
        sat_inc = 0; sat_clr = 0;
        @(negedge clk);

        // V1: addi, addi, add, ebreak
        use_prog = 1'b1; eb_pc = 32'hC;
        do_reset();
        commits0 = 0;
        tick();
        chk("v1_first_commit", commits0, 1);
        repeat (5) tick();
        chk("v1_commits", commits0, 3);
        chk("v1_halted", halted0, 1);
        chk("v1_cause", cause0, 2);
        chk("v1_count", cnt0, 3);
        chk("v1_pc", pc, 32'hC);

        // V2: host halt in the second run cycle, then resume
        eb_pc = 32'h100;
        do_reset();
        commits0 = 0;
        tick();
        halt_req = 1; tick(); halt_req = 0;
        chk("v2_commits", commits0, 2);
        chk("v2_halted", halted0, 1);
        chk("v2_cause", cause0, 1);
        tick();
        run_req = 1; tick(); run_req = 0;
        chk("v2_resumed", halted0, 0);
        chk("v2_resume_pc", pc, 32'h8);
        tick();
        chk("v2_next_pc", pc, 32'hC);

        // V3: two single steps from HALT
        halt_req = 1; tick(); halt_req = 0;
        base_cnt = int'(m_cnt[0]);
        c_before = commits0;
        sd_pulses0 = 0;
        repeat (2) begin
            step_req = 1; tick(); step_req = 0;
            tick(); tick();
        end
        chk("v3_commits", commits0 - c_before, 2);
        chk("v3_step_done", sd_pulses0, 2);
        chk("v3_cause", cause0, 3);
        chk("v3_count", cnt0, base_cnt + 2);

        // V4: run_req beats step_req
        sd_pulses0 = 0;
        c_before = commits0;
        run_req = 1; step_req = 1; tick(); run_req = 0; step_req = 0;
        chk("v4_running", halted0, 0);
        repeat (3) tick();
        chk("v4_no_step_done", sd_pulses0, 0);
        chk("v4_commits", commits0 - c_before, 3);

        // V5: watchdog on dut1 (MAX_CYCLES=4, starts halted)
        use_prog = 1'b0;
        do_reset();
        commits1 = 0;
        run_req = 1; tick(); run_req = 0;
        repeat (7) tick();
        chk("v5_commits", commits1, 4);
        chk("v5_halted", halted1, 1);
        chk("v5_cause", cause1, 4);
        chk("v5_count", cnt1, 4);
        c_before = commits1;
        run_req = 1; tick(); run_req = 0;
        tick(); tick();
        chk("v5_rehalt_commits", commits1 - c_before, 0);
        chk("v5_rehalt_cause", cause1, 4);
        chk("v5_rehalt_halted", halted1, 1);
        cnt_clr = 1; tick(); cnt_clr = 0;
        chk("v5_cleared", cnt1, 0);
        run_req = 1; tick(); run_req = 0;
        tick(); tick();
        chk("v5_resume_commits", commits1 - c_before, 2);

        // V6: reset lands while dut0 is in STEP
        do_reset();
        tick(); tick();
        halt_req = 1; tick(); halt_req = 0;
        step_req = 1; tick(); step_req = 0;
        sd_pulses0 = 0;
        do_reset();
        chk("v6_count", cnt0, 0);
        chk("v6_cause", cause0, 0);
        chk("v6_running", halted0, 0);
        repeat (3) tick();
        chk("v6_no_step_done", sd_pulses0, 0);

        // Vector table from reset on dut0
        vt[0]  = '{5'b00000, 3'b100, 3'd0, 32'd1};
        vt[1]  = '{5'b01000, 3'b110, 3'd1, 32'd2};
        vt[2]  = '{5'b01000, 3'b010, 3'd1, 32'd2};
        vt[3]  = '{5'b10000, 3'b000, 3'd1, 32'd2};
        vt[4]  = '{5'b00100, 3'b100, 3'd1, 32'd3};
        vt[5]  = '{5'b00010, 3'b010, 3'd2, 32'd3};
        vt[6]  = '{5'b00100, 3'b000, 3'd2, 32'd3};
        vt[7]  = '{5'b11000, 3'b111, 3'd3, 32'd4};
        vt[8]  = '{5'b00000, 3'b010, 3'd3, 32'd4};
        vt[9]  = '{5'b00110, 3'b000, 3'd3, 32'd4};
        vt[10] = '{5'b00010, 3'b010, 3'd2, 32'd4};
        vt[11] = '{5'b00001, 3'b010, 3'd2, 32'd0};
        vt[12] = '{5'b10001, 3'b000, 3'd2, 32'd0};
        vt[13] = '{5'b00001, 3'b100, 3'd2, 32'd0};
        vt[14] = '{5'b00000, 3'b100, 3'd2, 32'd1};
        do_reset();
        for (int i = 0; i < 15; i++) begin
            {run_req, halt_req, step_req, ebreak_det, cnt_clr} = vt[i].in_bits;
            tick();
            $display("vec %0d: in=%b en=%b halted=%b sd=%b cause=%0d count=%0d",
                     i, vt[i].in_bits, last_en0, halted0, sd0, cause0, cnt0);
            chk("tbl_cpu_en", last_en0, vt[i].out_bits[2]);
            chk("tbl_halted", halted0, vt[i].out_bits[1]);
            chk("tbl_step_done", sd0, vt[i].out_bits[0]);
            chk("tbl_cause", cause0, vt[i].cause);
            chk("tbl_count", cnt0, vt[i].count);
        end
        run_req = 0; halt_req = 0; step_req = 0; ebreak_det = 0; cnt_clr = 0;

        // Random stimulus against the model
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                do_reset();
            end else begin
                run_req    = ($urandom_range(0, 7) == 0);
                halt_req   = ($urandom_range(0, 7) == 0);
                step_req   = ($urandom_range(0, 5) == 0);
                ebreak_det = ($urandom_range(0, 9) == 0);
                cnt_clr    = ($urandom_range(0, 15) == 0);
                tick();
            end
        end
        run_req = 0; halt_req = 0; step_req = 0; ebreak_det = 0; cnt_clr = 0;

        // Saturation on a narrow counter instance: must stick at all-ones
        sat_clr = 1;
        @(posedge clk); #1;
        chk("sat_clear", sat_q, 0);
        @(negedge clk);
        sat_clr = 0; sat_inc = 1;
        repeat (14) @(posedge clk);
        #1;
        chk("sat_near_top", sat_q, 4'hE);
        @(negedge clk);
        st[0] = '{1'b1, 1'b0, 4'hF};
        st[1] = '{1'b1, 1'b0, 4'hF};
        st[2] = '{1'b0, 1'b0, 4'hF};
        st[3] = '{1'b1, 1'b1, 4'h0};
        st[4] = '{1'b0, 1'b1, 4'h0};
        st[5] = '{1'b1, 1'b0, 4'h1};
        for (int i = 0; i < 6; i++) begin
            sat_inc = st[i].inc;
            sat_clr = st[i].clr;
            @(posedge clk); #1;
            $display("sat %0d: inc=%b clr=%b q=%0h", i, st[i].inc, st[i].clr, sat_q);
            chk("sat_q", sat_q, st[i].q);
            @(negedge clk);
        end
        sat_inc = 0; sat_clr = 0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/cpu_run_ctrl.md
CPU_RUN_CTRL -- requirements
Module: cpu_run_ctrl

Interface
REQ-001 Parameters SHALL be one per line: name, default, meaning.
- AUTO_RUN, 1: state entered on reset (1=RUN, 0=HALT).
- MAX_CYCLES, 0: watchdog limit on committed cycles (0=disabled).
REQ-002 Ports SHALL be one per line: name, direction, width, meaning.
- clk, in, 1: single clock, rising edge.
- reset, in, 1: asynchronous, active-low reset.
- run_req, in, 1: host request to resume from HALT.
- halt_req, in, 1: host request to halt.
- step_req, in, 1: host request to execute exactly one instruction from HALT.
- ebreak_det, in, 1: decoder flags current instruction as EBREAK.
- cnt_clr, in, 1: synchronous clear of cycle_count.
- cpu_en, out, 1: commit enable for PC and register file writes.
- halted, out, 1: controller is in HALT.
- step_done, out, 1: one-cycle pulse after a step completes.
- halt_cause, out, 3: 0 NONE, 1 HOST, 2 EBREAK, 3 STEP, 4 TIMEOUT.
- cycle_count, out, 32: count of cycles with cpu_en=1.

Function
REQ-003 The FSM SHALL have three states: RUN, HALT and STEP.
REQ-004 cpu_en SHALL equal (state is RUN or STEP) AND NOT ebreak_det AND NOT wd_hit, where wd_hit = (MAX_CYCLES != 0 and cycle_count == MAX_CYCLES).
REQ-005 In RUN, transition priority SHALL be: ebreak_det -> HALT/EBREAK, then wd_hit -> HALT/TIMEOUT, then halt_req -> HALT/HOST; otherwise remain in RUN.
REQ-006 On a halt_req from RUN, the instruction in that cycle SHALL still commit (cpu_en=1).
REQ-007 An EBREAK instruction SHALL never commit, so the PC stays on the EBREAK.
REQ-008 In HALT, run_req SHALL transition to RUN, else step_req SHALL transition to STEP, else HALT holds.
- Simultaneous run_req and step_req: run_req wins.
- halt_req in HALT is ignored.
REQ-009 STEP SHALL last exactly one cycle, then go to HALT.
- halt_cause is EBREAK if ebreak_det, else TIMEOUT if wd_hit, else STEP.
- step_done SHALL pulse on the cycle after STEP only when cause is STEP.
- halt_req and run_req during STEP are ignored.
REQ-010 run_req and step_req in RUN SHALL be ignored.
REQ-011 halt_cause SHALL update only on entry to HALT and hold until the next HALT entry.
REQ-012 Resuming onto an EBREAK SHALL re-halt on the next cycle with cause EBREAK and zero commits; the host must redirect the PC.
REQ-013 cycle_count SHALL increment by 1 each cycle cpu_en=1 and saturate at 0xFFFFFFFF.
- cnt_clr forces 0 and has priority over increment.
REQ-014 Once wd_hit, any resume SHALL immediately re-halt with cause TIMEOUT until cnt_clr is asserted.
REQ-015 halted SHALL equal 1 exactly when state is HALT.
REQ-016 All outputs other than cpu_en SHALL be registered; cpu_en is combinational from state and inputs.

Reset
REQ-017 While reset=0, the block SHALL hold, asynchronously:
- state = RUN if AUTO_RUN else HALT;
- halt_cause = NONE; step_done = 0; cycle_count = 0.
REQ-018 Reset asserted mid-RUN or mid-STEP SHALL abort immediately, with no step_done pulse.
REQ-019 After reset deassertion with AUTO_RUN=1, the first commit SHALL occur on the first rising edge.

Structure
REQ-020 Package cpu_ctrl_pkg SHALL hold the state enum (RUN, HALT, STEP) and the halt_cause codes, shared with the CPU top and benches.
REQ-021 The saturating clearable counter SHALL be a sub-module, sat_counter (WIDTH=32, inc, clr, q).
REQ-022 The block SHALL be instantiated in cpu, gating PC and register-file write enables with cpu_en and driving the cpu cycle_count port.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- V1: AUTO_RUN=1, program addi, addi, add, ebreak -> cpu_en high 3 cycles, then halted=1, halt_cause=2, cycle_count=3, PC=0xC.
- V2: halt_req pulsed in 2nd RUN cycle -> 2 commits, halted=1, halt_cause=1; run_req -> resumes at PC=0x8.
- V3: From HALT, step_req x2 -> exactly 2 commits, step_done pulses twice, halt_cause=3, cycle_count +2.
- V4: run_req and step_req same cycle in HALT -> RUN entered, no step_done.
- V5: MAX_CYCLES=4, no ebreak -> halt with cycle_count=4, cause=4; run_req re-halts, 0 commits; cnt_clr then run_req -> commits resume.
- V6: Reset asserted mid-STEP -> cycle_count=0, halt_cause=0, step_done never pulses; saturation forced at 0xFFFFFFFE -> stays 0xFFFFFFFF.
